hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl_pkg.sv | 73 +++++++
 rtl/hazard_ctrl_if.sv | 53 +++++
 rtl/hazard_ctrl_perf_counter.sv | 33 +++
 rtl/hazard_ctrl.sv | 133 +++++++++++++
 tb/tb_hazard_ctrl.sv | 319 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_ctrl_pkg
//  Description : Shared pipeline definitions for the hazard controller:
//                FSM state encoding, hazard-priority rules and the control
//                word each rule drives, plus pipeline register reset values.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package hazard_ctrl_pkg;

    // FSM state encoding; kept as plain 2-bit constants so the value on
    // state_out matches legacy tooling that decodes it numerically.
    typedef logic [1:0] state_t;
    localparam state_t c_ST_RUN       = 2'd0;
    localparam state_t c_ST_DSTALL    = 2'd1;
    localparam state_t c_ST_DSTALL_BR = 2'd2;
    localparam state_t c_ST_ERR       = 2'd3;

    // Hazard rules, listed from highest to lowest priority.
    typedef enum logic [2:0] {
        PRIO_NONE      = 3'd0,
        PRIO_MEM_STALL = 3'd1,  // ERR or data memory not ready
        PRIO_BR_FLUSH  = 3'd2,  // taken branch, or deferred branch completing
        PRIO_LOAD_USE  = 3'd3,  // load result needed by the next instruction
        PRIO_IMEM_WAIT = 3'd4   // instruction fetch not ready
    } prio_e;

    typedef struct packed {
        logic pc_stall;
        logic ifid_stall;
        logic idex_stall;
        logic exmem_stall;
        logic ifid_flush;
        logic idex_flush;
    } ctrl_t;

    // Reset values of the pipeline registers controlled by this block.
    localparam logic [31:0] c_PC_RESET  = 32'h0000_0000;
    localparam logic [31:0] c_NOP_INSTR = 32'h0000_0013;  // addi x0,x0,0

    // Control word driven by each rule. No rule raises stall and flush of
    // the same register together.
    function automatic ctrl_t prio_ctrl(input prio_e prio);
        ctrl_t c;
        c = '0;
        case (prio)
            PRIO_MEM_STALL: begin
                c.pc_stall    = 1'b1;
                c.ifid_stall  = 1'b1;
                c.idex_stall  = 1'b1;
                c.exmem_stall = 1'b1;
            end
            PRIO_BR_FLUSH: begin
                c.ifid_flush = 1'b1;
                c.idex_flush = 1'b1;
            end
            PRIO_LOAD_USE: begin
                c.pc_stall   = 1'b1;
                c.ifid_stall = 1'b1;
                c.idex_flush = 1'b1;
            end
            PRIO_IMEM_WAIT: begin
                c.pc_stall   = 1'b1;
                c.ifid_flush = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_ctrl_if
//  Description : Pipeline <-> hazard controller signal bundle.
//  Ports       : id_rs1_in/id_rs2_in/ex_rd_in   register addresses
//                ex_memread_in, branch_taken_in  EX-stage status
//                imem_ready_in, dmem_ready_in    memory readiness
//                *_stall_out, *_flush_out        pipeline register control
//                err_out, state_out              status
//                stall_cnt_out, flush_cnt_out    performance counters
//                modport slave  : hazard controller side
//                modport master : pipeline side
//  Revision    : 1.0 - initial release
// ============================================================================
interface hazard_ctrl_if #(
    parameter int WIDTH    = 32,
    parameter int REG_ADDR = 5
);
    logic [REG_ADDR-1:0] id_rs1_in;
    logic [REG_ADDR-1:0] id_rs2_in;
    logic [REG_ADDR-1:0] ex_rd_in;
    logic                ex_memread_in;
    logic                branch_taken_in;
    logic                imem_ready_in;
    logic                dmem_ready_in;
    logic                pc_stall_out;
    logic                ifid_stall_out;
    logic                idex_stall_out;
    logic                exmem_stall_out;
    logic                ifid_flush_out;
    logic                idex_flush_out;
    logic                err_out;
    logic [1:0]          state_out;
    logic [WIDTH-1:0]    stall_cnt_out;
    logic [WIDTH-1:0]    flush_cnt_out;

    modport slave (
        input  id_rs1_in, id_rs2_in, ex_rd_in, ex_memread_in, branch_taken_in,
               imem_ready_in, dmem_ready_in,
        output pc_stall_out, ifid_stall_out, idex_stall_out, exmem_stall_out,
               ifid_flush_out, idex_flush_out, err_out, state_out,
               stall_cnt_out, flush_cnt_out
    );

    modport master (
        output id_rs1_in, id_rs2_in, ex_rd_in, ex_memread_in, branch_taken_in,
               imem_ready_in, dmem_ready_in,
        input  pc_stall_out, ifid_stall_out, idex_stall_out, exmem_stall_out,
               ifid_flush_out, idex_flush_out, err_out, state_out,
               stall_cnt_out, flush_cnt_out
    );
endinterface
`default_nettype wire

// File: rtl/hazard_ctrl_perf_counter.sv
`default_nettype none
// ============================================================================
//  Module      : perf_counter
//  Description : Free-running event counter, wraps modulo 2^WIDTH.
//  Ports       : clk_in    clock
//                rst_in    asynchronous active-low reset, clears the count
//                en_in     count this cycle
//                count_out current count
//  Revision    : 1.0 - initial release
// ============================================================================
module perf_counter #(
    parameter int WIDTH = 32
) (
    input  wire logic             clk_in,
    input  wire logic             rst_in,
    input  wire logic             en_in,
    output logic      [WIDTH-1:0] count_out
);
    localparam logic [WIDTH-1:0] c_ONE = WIDTH'(1);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_count <= '0;
        end else if (en_in) begin
            r_count <= r_count + c_ONE;
        end
    end

    assign count_out = r_count;
endmodule
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_ctrl
//  Description : Pipeline hazard controller. Tracks data-memory waits in a
//                small FSM (with branch deferral and timeout to a sticky
//                error) and resolves stall/flush controls by fixed priority.
//  Ports       : clk_in  clock, rising edge
//                rst_in  asynchronous active-low reset
//                bus     hazard_ctrl_if.slave (inputs, controls, status,
//                        performance counters)
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int REG_ADDR = 5,
    parameter int TIMEOUT  = 255
) (
    input  wire logic     clk_in,
    input  wire logic     rst_in,
    hazard_ctrl_if.slave  bus
);
    localparam int                  c_WAIT_W    = $clog2(TIMEOUT + 1);
    localparam logic [c_WAIT_W-1:0] c_WAIT_MAX  = c_WAIT_W'(TIMEOUT);
    localparam logic [c_WAIT_W-1:0] c_WAIT_LAST = c_WAIT_W'(TIMEOUT - 1);
    localparam logic [c_WAIT_W-1:0] c_WAIT_ONE  = c_WAIT_W'(1);
    localparam logic [REG_ADDR-1:0] c_REG_ZERO  = '0;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [c_WAIT_W-1:0] r_wait_cnt;
    logic                w_wait_done;
    logic                w_load_use;
    prio_e               w_prio;
    ctrl_t               w_ctrl;

    // The cycle being evaluated is the TIMEOUT-th wait cycle, so the count
    // reaches TIMEOUT exactly as the FSM moves to ERR.
    assign w_wait_done = (r_wait_cnt >= c_WAIT_LAST);

    assign w_load_use = bus.ex_memread_in && (bus.ex_rd_in != c_REG_ZERO) &&
                        ((bus.ex_rd_in == bus.id_rs1_in) ||
                         (bus.ex_rd_in == bus.id_rs2_in));

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_RUN: begin
                if (!bus.dmem_ready_in) begin
                    w_state_nxt = bus.branch_taken_in ? c_ST_DSTALL_BR : c_ST_DSTALL;
                end
            end
            c_ST_DSTALL: begin
                if (bus.dmem_ready_in) begin
                    w_state_nxt = c_ST_RUN;
                end else if (bus.branch_taken_in) begin
                    w_state_nxt = c_ST_DSTALL_BR;
                end else if (w_wait_done) begin
                    w_state_nxt = c_ST_ERR;
                end
            end
            c_ST_DSTALL_BR: begin
                if (bus.dmem_ready_in) begin
                    w_state_nxt = c_ST_RUN;
                end else if (w_wait_done) begin
                    w_state_nxt = c_ST_ERR;
                end
            end
            default: w_state_nxt = c_ST_ERR;  // ERR only leaves via reset
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_state <= c_ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Holding zero throughout RUN gives a fresh count on every stall entry.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_wait_cnt <= '0;
        end else if (r_state == c_ST_RUN) begin
            r_wait_cnt <= '0;
        end else if ((r_state != c_ST_ERR) && (r_wait_cnt != c_WAIT_MAX)) begin
            r_wait_cnt <= r_wait_cnt + c_WAIT_ONE;
        end
    end

    // A branch seen while waiting on data memory is parked in DSTALL_BR and
    // its flush is issued on the cycle the memory finally becomes ready.
    always_comb begin
        w_prio = PRIO_NONE;
        if ((r_state == c_ST_ERR) || !bus.dmem_ready_in) begin
            w_prio = PRIO_MEM_STALL;
        end else if (bus.branch_taken_in || (r_state == c_ST_DSTALL_BR)) begin
            w_prio = PRIO_BR_FLUSH;
        end else if (w_load_use) begin
            w_prio = PRIO_LOAD_USE;
        end else if (!bus.imem_ready_in) begin
            w_prio = PRIO_IMEM_WAIT;
        end
    end

    assign w_ctrl = prio_ctrl(w_prio);

    assign bus.pc_stall_out    = w_ctrl.pc_stall;
    assign bus.ifid_stall_out  = w_ctrl.ifid_stall;
    assign bus.idex_stall_out  = w_ctrl.idex_stall;
    assign bus.exmem_stall_out = w_ctrl.exmem_stall;
    assign bus.ifid_flush_out  = w_ctrl.ifid_flush;
    assign bus.idex_flush_out  = w_ctrl.idex_flush;
    assign bus.err_out         = (r_state == c_ST_ERR);
    assign bus.state_out       = r_state;

    perf_counter #(.WIDTH(WIDTH)) u_stall_cnt (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .en_in     (w_ctrl.pc_stall),
        .count_out (bus.stall_cnt_out)
    );

    perf_counter #(.WIDTH(WIDTH)) u_flush_cnt (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .en_in     (w_ctrl.ifid_flush),
        .count_out (bus.flush_cnt_out)
    );
endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hazard_ctrl
//  Description : Self-checking bench for hazard_ctrl with a behavioural model
//                of the wait FSM, hazard priorities and counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;
    localparam int WIDTH    = 4;
    localparam int REG_ADDR = 5;
    localparam int TIMEOUT  = 4;
    localparam int MODW     = 1 << WIDTH;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    // model state: 0 run, 1 data wait, 2 data wait with branch pending, 3 error
    int   m_state;
    int   m_wait;
    int   m_stall;
    int   m_flush;

    logic [4:0] cur_rs1, cur_rs2, cur_rd;
    logic       cur_mr, cur_br, cur_ir, cur_dr;

    hazard_ctrl_if #(.WIDTH(WIDTH), .REG_ADDR(REG_ADDR)) bus ();

    hazard_ctrl #(.WIDTH(WIDTH), .REG_ADDR(REG_ADDR), .TIMEOUT(TIMEOUT)) dut (
        .clk_in (clk),
        .rst_in (rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {pc_st, ifid_st, idex_st, exmem_st, ifid_fl, idex_fl, err, state[1:0]}
    function automatic logic [8:0] obs();
        return {bus.pc_stall_out, bus.ifid_stall_out, bus.idex_stall_out,
                bus.exmem_stall_out, bus.ifid_flush_out, bus.idex_flush_out,
                bus.err_out, bus.state_out};
    endfunction

    function automatic logic [8:0] exp_out();
        logic       lu;
        logic [5:0] c;
        lu = cur_mr && (cur_rd != 0) && ((cur_rd == cur_rs1) || (cur_rd == cur_rs2));
        if (m_state == 3 || !cur_dr)            c = 6'b111100;
        else if (cur_br || m_state == 2)        c = 6'b000011;
        else if (lu)                            c = 6'b110001;
        else if (!cur_ir)                       c = 6'b100010;
        else                                    c = 6'b000000;
        return {c, (m_state == 3), 2'(m_state)};
    endfunction

    function automatic void model_reset();
        m_state = 0; m_wait = 0; m_stall = 0; m_flush = 0;
    endfunction

    function automatic void model_step();
        logic [8:0] e;
        e = exp_out();
        if (e[8]) m_stall = (m_stall + 1) % MODW;
        if (e[4]) m_flush = (m_flush + 1) % MODW;
        case (m_state)
            0: if (!cur_dr) begin m_state = cur_br ? 2 : 1; m_wait = 0; end
            1, 2: begin
                m_wait = (m_wait + 1 > TIMEOUT) ? TIMEOUT : m_wait + 1;
                if (cur_dr)                     m_state = 0;
                else if (m_state == 1 && cur_br) m_state = 2;
                else if (m_wait >= TIMEOUT)     m_state = 3;
            end
            default: m_state = 3;
        endcase
    endfunction

    task automatic set_in(input logic [4:0] rs1, rs2, rd, input logic mr, br, ir, dr);
        cur_rs1 = rs1; cur_rs2 = rs2; cur_rd = rd;
        cur_mr = mr; cur_br = br; cur_ir = ir; cur_dr = dr;
        bus.id_rs1_in = rs1; bus.id_rs2_in = rs2; bus.ex_rd_in = rd;
        bus.ex_memread_in = mr; bus.branch_taken_in = br;
        bus.imem_ready_in = ir; bus.dmem_ready_in = dr;
    endtask

    // Apply inputs just after a rising edge and settle to the falling edge.
    task automatic drive(input logic [4:0] rs1, rs2, rd, input logic mr, br, ir, dr);
        set_in(rs1, rs2, rd, mr, br, ir, dr);
        @(negedge clk);
    endtask

    task automatic idle();
        drive(5'd1, 5'd2, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_assert();
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
    endtask

    task automatic reset_release();
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        set_in(5'd1, 5'd2, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        rst_n = 1'b0;
        model_reset();
        #2;
        checks++;
        if (obs() !== 9'b000000_0_00) begin
            failures++; $display("FAIL reset_out: got %b exp %b", obs(), 9'b0);
        end
        checks++;
        if (bus.stall_cnt_out !== 4'd0 || bus.flush_cnt_out !== 4'd0) begin
            failures++; $display("FAIL reset_cnt: got %0d/%0d exp 0/0", bus.stall_cnt_out, bus.flush_cnt_out);
        end
        #10;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_load_use();
        int s0;
        s0 = m_stall;
        drive(5'd5, 5'd9, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1);
        checks++;
        if (obs() !== 9'b110001_0_00) begin
            failures++; $display("FAIL load_use_out: got %b exp %b", obs(), 9'b110001000);
        end
        tick();
        idle();
        checks++;
        if (obs() !== 9'b000000_0_00) begin
            failures++; $display("FAIL load_use_one_cycle: got %b exp %b", obs(), 9'b0);
        end
        checks++;
        if (bus.stall_cnt_out !== 4'((s0 + 1) % MODW)) begin
            failures++; $display("FAIL load_use_cnt: got %0d exp %0d", bus.stall_cnt_out, (s0 + 1) % MODW);
        end
        tick();
    endtask

    task automatic test_load_x0();
        drive(5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1);
        checks++;
        if (obs() !== 9'b000000_0_00) begin
            failures++; $display("FAIL load_x0_out: got %b exp %b", obs(), 9'b0);
        end
        tick();
    endtask

    task automatic test_dstall_branch();
        int s0, f0;
        logic [8:0] exp_seq [4];
        logic       br_seq  [4];
        logic       dr_seq  [4];
        s0 = m_stall; f0 = m_flush;
        exp_seq = '{9'b111100_0_00, 9'b111100_0_01, 9'b111100_0_10, 9'b000011_0_10};
        br_seq  = '{1'b0, 1'b1, 1'b0, 1'b0};
        dr_seq  = '{1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++) begin
            drive(5'd1, 5'd2, 5'd0, 1'b0, br_seq[i], 1'b1, dr_seq[i]);
            checks++;
            if (obs() !== exp_seq[i]) begin
                failures++; $display("FAIL dstall_br_c%0d: got %b exp %b", i, obs(), exp_seq[i]);
            end
            tick();
        end
        idle();
        checks++;
        if (obs() !== 9'b000000_0_00) begin
            failures++; $display("FAIL dstall_br_back_to_run: got %b exp %b", obs(), 9'b0);
        end
        checks++;
        if (bus.stall_cnt_out !== 4'((s0 + 3) % MODW) || bus.flush_cnt_out !== 4'((f0 + 1) % MODW)) begin
            failures++; $display("FAIL dstall_br_cnt: got %0d/%0d exp %0d/%0d", bus.stall_cnt_out,
                                 bus.flush_cnt_out, (s0 + 3) % MODW, (f0 + 1) % MODW);
        end
        tick();
    endtask

    task automatic test_timeout();
        drive(5'd1, 5'd2, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        checks++;
        if (obs() !== 9'b111100_0_00) begin
            failures++; $display("FAIL timeout_enter: got %b exp %b", obs(), 9'b111100000);
        end
        tick();
        for (int i = 0; i < TIMEOUT; i++) begin
            drive(5'd1, 5'd2, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
            checks++;
            if (obs() !== 9'b111100_0_01) begin
                failures++; $display("FAIL timeout_wait_c%0d: got %b exp %b", i, obs(), 9'b111100001);
            end
            tick();
        end
        for (int i = 0; i < 2; i++) begin
            drive(5'd1, 5'd2, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
            checks++;
            if (obs() !== 9'b111100_1_11) begin
                failures++; $display("FAIL timeout_err_c%0d: got %b exp %b", i, obs(), 9'b111100111);
            end
            tick();
        end
        reset_assert();
        checks++;
        if (obs() !== 9'b000000_0_00 || bus.stall_cnt_out !== 4'd0 || bus.flush_cnt_out !== 4'd0) begin
            failures++; $display("FAIL timeout_reset: got %b cnt %0d/%0d exp %b cnt 0/0", obs(),
                                 bus.stall_cnt_out, bus.flush_cnt_out, 9'b0);
        end
        reset_release();
    endtask

    task automatic test_priority();
        drive(5'd7, 5'd3, 5'd7, 1'b1, 1'b1, 1'b0, 1'b1);
        checks++;
        if (obs() !== 9'b000011_0_00) begin
            failures++; $display("FAIL prio_p2_wins: got %b exp %b", obs(), 9'b000011000);
        end
        tick();
        drive(5'd4, 5'd7, 5'd7, 1'b1, 1'b0, 1'b0, 1'b1);
        checks++;
        if (obs() !== 9'b110001_0_00) begin
            failures++; $display("FAIL prio_p3_over_p4: got %b exp %b", obs(), 9'b110001000);
        end
        tick();
        drive(5'd4, 5'd6, 5'd7, 1'b1, 1'b0, 1'b0, 1'b1);
        checks++;
        if (obs() !== 9'b100010_0_00) begin
            failures++; $display("FAIL prio_p4_imem: got %b exp %b", obs(), 9'b100010000);
        end
        tick();
    endtask

    task automatic test_wrap();
        int n;
        n = (MODW - 1 - m_stall + MODW) % MODW;
        for (int i = 0; i < n; i++) begin
            drive(5'd3, 5'd0, 5'd3, 1'b1, 1'b0, 1'b1, 1'b1);
            tick();
        end
        idle();
        checks++;
        if (bus.stall_cnt_out !== 4'hF) begin
            failures++; $display("FAIL wrap_preload: got %0d exp %0d", bus.stall_cnt_out, MODW - 1);
        end
        tick();
        drive(5'd3, 5'd0, 5'd3, 1'b1, 1'b0, 1'b1, 1'b1);
        tick();
        idle();
        checks++;
        if (bus.stall_cnt_out !== 4'd0) begin
            failures++; $display("FAIL wrap_to_zero: got %0d exp 0", bus.stall_cnt_out);
        end
        tick();
    endtask

    task automatic test_random();
        logic [8:0] e;
        logic [8:0] o;
        for (int i = 0; i < 400; i++) begin
            if (m_state == 3 && $urandom_range(0, 3) == 0) begin
                set_in(5'd1, 5'd2, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
                reset_assert();
                checks++;
                if (bus.stall_cnt_out !== 4'd0 || bus.state_out !== 2'd0) begin
                    failures++; $display("FAIL rand_reset_i%0d: cnt %0d state %0d exp 0 0", i,
                                         bus.stall_cnt_out, bus.state_out);
                end
                reset_release();
            end
            drive(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                  ($urandom_range(0, 2) == 0), ($urandom_range(0, 4) == 0),
                  ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0));
            e = exp_out();
            o = obs();
            checks++;
            if (o !== e || o[8:7] == 2'b11 && o[4] || o[6] && o[3]) begin
                failures++; $display("FAIL rand_out_i%0d: got %b exp %b", i, o, e);
            end
            checks++;
            if (bus.stall_cnt_out !== 4'(m_stall) || bus.flush_cnt_out !== 4'(m_flush)) begin
                failures++; $display("FAIL rand_cnt_i%0d: got %0d/%0d exp %0d/%0d", i,
                                     bus.stall_cnt_out, bus.flush_cnt_out, m_stall, m_flush);
            end
            tick();
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_load_use();
        test_load_x0();
        test_dstall_branch();
        test_priority();
        test_timeout();
        test_wrap();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
